seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Receive-side counterpart of the decimal-to-segment encoder: monitors a time-multiplexed, active-low 7-segment bus (segment lines plus one-hot anode selects), turns each settled segment pattern back into a digit code, and assembles one complete frame per scan. When all digit positions have been captured, it accumulates the decimal value sequentially and pulses a valid strobe. It sits in the snake-game test infrastructure, on the display pins of the score/display path, so score output can be checked numerically instead of by pattern.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digit positions; anode bit i is decimal weight 10^i.
- SETTLE, 4: consecutive stable cycles required before a pattern is captured (≥1).
- VALUE_W, 14: width of the accumulated value; must satisfy 2^VALUE_W > 10^NUM_DIGITS − 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- seg  in  7  segment lines, active-low; bit0 = a … bit6 = g (0 is 7'b1000000).
- an  in  NUM_DIGITS  anode selects, active-low, expected one-hot-low.
- digits  out  4*NUM_DIGITS  captured digit codes, nibble i = position i.
- value  out  VALUE_W  decimal value of the last good frame.
- frame_valid  out  1  one-cycle pulse when value/digits update.
- frame_err  out  1  one-cycle pulse (same cycle as frame_valid) when the frame held a dash or invalid code; value then holds its previous content.

## Operation
- Pattern decode (combinational) is the exact inverse of the encoder table:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - 0111111→code 10 (dash).
  - Any other pattern → code 15 (invalid).
- Anode check: an with exactly one low bit selects a position. All-high (blanking) or multiple low bits is "no position". No capture happens, and the settle counter is held at 0.
- Capture FSM:
  - IDLE: wait for a valid position → SETTLE.
  - SETTLE: count cycles while {seg, an} is unchanged from the previous cycle. Any change restarts the count at 1 (or goes to IDLE if no position). When the count reaches SETTLE → CAPTURE.
  - CAPTURE (1 cycle): write the code into the digit register for that position and set its bit in the captured mask → HOLD.
  - HOLD: ignore seg until an changes; then → SETTLE or IDLE. Each anode activation captures at most once. A seg change under the same anode is not recaptured.
- Frame assembly:
  - When the captured mask is all ones, snapshot the digit registers into the accumulator shadow and clear the mask in the same cycle.
  - Start ACCUM: NUM_DIGITS cycles, most significant digit first, acc = acc*10 + d (acc*10 implemented as (acc<<3)+(acc<<1)).
  - Codes ≥10 set a sticky err flag.
  - After the last digit, a DONE cycle drives frame_valid=1. digits is updated from the snapshot. value is updated only if err=0; otherwise frame_err=1.
- Captures continue during ACCUM into the live registers/mask. A new frame completing during ACCUM is held pending and starts on the cycle after DONE. Only one frame can be pending; a further completion overwrites the pending snapshot.

## Timing
- Reset (async): FSMs IDLE, mask 0, counter 0, pending 0, digits all 0, value 0, frame_valid 0, frame_err 0.
- Capture latency: SETTLE cycles of stable input after the anode edge, plus 1 (CAPTURE).
- Frame latency: mask-full cycle, then NUM_DIGITS ACCUM cycles, then 1 DONE cycle. frame_valid is asserted NUM_DIGITS+1 cycles after the mask becomes full.
- Reset asserted mid-ACCUM aborts the frame with no pulse. Capture restarts from an empty mask after release.
- Inputs are sampled synchronously. The bench/top drives them from the clk domain; no synchronizer in this block.

## Structure
- Shared package seg7_pkg holds:
  - the 7-bit pattern constants SEG_0…SEG_9 and SEG_DASH;
  - the code constants CODE_DASH=10 and CODE_INV=15;
  - the capture FSM state enum (IDLE, SETTLE, CAPTURE, HOLD) and the accumulator state enum (ACC_IDLE, ACC_RUN, ACC_DONE).
- One sub-module: seg7_pattern_decode (7-bit pattern → 4-bit code, purely combinational), reusable by other monitors.

## Test plan
- Scan 0,4,2,1 (an=1110,1101,1011,0111 with patterns for 1,2,4,0 on positions 0..3), 8 cycles each, SETTLE=4 → frame_valid once, value=0421, digits=16'h0421, frame_err=0.
- Glitch: position 0 pattern changes at cycle 2 of settle (7→9), then stable → digit 0 captured as 9 only after 4 stable cycles; no capture of 7.
- Dash on position 2 (0111111) in an otherwise valid scan → frame_valid=1, frame_err=1, digit2=4'hA, value keeps the prior 0421.
- Blanking an=1111 and double select an=1100 for 10 cycles → no capture, mask unchanged, no strobes.
- Full scan 9999 → value=9999 (14'h270F); second identical scan started during ACCUM → exactly two frame_valid pulses, the second following DONE by ≥1 cycle.
- Assert reset during ACCUM → no frame_valid, all outputs 0; next full scan produces a correct frame.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared 7-segment pattern/code constants and FSM state types
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam logic [3:0] CODE_DASH = 4'd10;
    localparam logic [3:0] CODE_INV  = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } cap_state_t;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_RUN  = 2'd1,
        ACC_DONE = 2'd2
    } acc_state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pattern_decode
//  Description : Active-low 7-segment pattern to 4-bit digit code (0-9, dash, invalid)
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode (
    input  logic [6:0] i_seg,
    output logic [3:0] o_code
);
    import seg7_pkg::*;

    always_comb begin
        case (i_seg)
            SEG_0:    o_code = 4'd0;
            SEG_1:    o_code = 4'd1;
            SEG_2:    o_code = 4'd2;
            SEG_3:    o_code = 4'd3;
            SEG_4:    o_code = 4'd4;
            SEG_5:    o_code = 4'd5;
            SEG_6:    o_code = 4'd6;
            SEG_7:    o_code = 4'd7;
            SEG_8:    o_code = 4'd8;
            SEG_9:    o_code = 4'd9;
            SEG_DASH: o_code = CODE_DASH;
            default:  o_code = CODE_INV;
        endcase
    end

endmodule : seg7_pattern_decode
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_decoder
//  Description : Monitors a multiplexed active-low 7-seg bus, captures settled
//                digits per anode and converts each full frame to a binary value
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int SETTLE     = 4,
    parameter int VALUE_W    = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [VALUE_W-1:0]      value,
    output logic                    frame_valid,
    output logic                    frame_err
);
    import seg7_pkg::*;

    localparam int               CNT_W    = $clog2(SETTLE + 1);
    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Capture side
    cap_state_t                  cap_state_q, cap_state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_DIGITS+6:0]       prev_q, prev_d;
    logic [NUM_DIGITS-1:0]       an_cap_q, an_cap_d;
    logic [IDX_W-1:0]            pos_q, pos_d;
    logic [3:0]                  code_q, code_d;
    logic [4*NUM_DIGITS-1:0]     live_q, live_d;
    logic [NUM_DIGITS-1:0]       mask_q, mask_d;

    // Accumulator side
    acc_state_t                  acc_state_q, acc_state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [VALUE_W-1:0]          acc_q, acc_d;
    logic                        err_q, err_d;
    logic [4*NUM_DIGITS-1:0]     shadow_q, shadow_d;
    logic                        pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0]     pend_snap_q, pend_snap_d;
    logic [4*NUM_DIGITS-1:0]     digits_q, digits_d;
    logic [VALUE_W-1:0]          value_q, value_d;
    logic                        frame_valid_q, frame_valid_d;
    logic                        frame_err_q, frame_err_d;

    logic [3:0]                  w_code;
    logic                        w_pos_ok;
    logic [IDX_W-1:0]            w_pos_idx;
    logic                        w_changed;
    logic [CNT_W-1:0]            w_cnt_inc;
    logic [NUM_DIGITS-1:0]       w_cap_bit;
    logic                        w_mask_full;
    logic [3:0]                  w_cur;
    logic [VALUE_W-1:0]          w_acc_step;
    logic                        w_err_step;

    seg7_pattern_decode u_decode (
        .i_seg  (seg),
        .o_code (w_code)
    );

    // A position is selected only when exactly one anode is driven low
    assign w_pos_ok = $onehot(~an);

    always_comb begin
        w_pos_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) w_pos_idx = IDX_W'(i);
        end
    end

    always_comb begin
        cap_state_d = cap_state_q;
        cnt_d       = cnt_q;
        an_cap_d    = an_cap_q;
        pos_d       = pos_q;
        code_d      = code_q;
        live_d      = live_q;
        w_cap_bit   = '0;
        prev_d      = {seg, an};
        w_changed   = ({seg, an} != prev_q);
        w_cnt_inc   = w_changed ? CNT_W'(1) : cnt_q + CNT_W'(1);

        case (cap_state_q)
            IDLE, HOLD: begin
                // HOLD ignores seg entirely; only a new anode value re-arms capture
                if ((cap_state_q == IDLE) || (an != an_cap_q)) begin
                    if (w_pos_ok) begin
                        cnt_d       = CNT_W'(1);
                        an_cap_d    = an;
                        pos_d       = w_pos_idx;
                        code_d      = w_code;
                        cap_state_d = (CNT_W'(1) >= SETTLE_C) ? CAPTURE : seg7_pkg::SETTLE;
                    end else begin
                        cnt_d       = '0;
                        cap_state_d = IDLE;
                    end
                end
            end
            seg7_pkg::SETTLE: begin
                if (!w_pos_ok) begin
                    cnt_d       = '0;
                    cap_state_d = IDLE;
                end else begin
                    cnt_d    = w_cnt_inc;
                    an_cap_d = an;
                    pos_d    = w_pos_idx;
                    code_d   = w_code;
                    if (w_cnt_inc >= SETTLE_C) cap_state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (pos_q == IDX_W'(i)) begin
                        live_d[4*i +: 4] = code_q;
                        w_cap_bit[i]     = 1'b1;
                    end
                end
                cap_state_d = HOLD;
            end
            default: cap_state_d = IDLE;
        endcase
    end

    assign w_mask_full = &mask_q;
    assign mask_d      = (w_mask_full ? '0 : mask_q) | w_cap_bit;

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) w_cur = shadow_q[4*i +: 4];
        end
        w_acc_step = (acc_q << 3) + (acc_q << 1) + VALUE_W'(w_cur);
        w_err_step = err_q | (w_cur >= CODE_DASH);

        acc_state_d   = acc_state_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        err_d         = err_q;
        shadow_d      = shadow_q;
        pend_d        = pend_q;
        pend_snap_d   = pend_snap_q;
        digits_d      = digits_q;
        value_d       = value_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        case (acc_state_q)
            ACC_IDLE: begin
                if (w_mask_full) begin
                    acc_state_d = ACC_RUN;
                    shadow_d    = live_q;
                    idx_d       = LAST_IDX;
                    acc_d       = '0;
                    err_d       = 1'b0;
                end
            end
            ACC_RUN: begin
                acc_d = w_acc_step;
                err_d = w_err_step;
                if (idx_q == '0) begin
                    acc_state_d   = ACC_DONE;
                    frame_valid_d = 1'b1;
                    digits_d      = shadow_q;
                    if (w_err_step) frame_err_d = 1'b1;
                    else            value_d     = w_acc_step;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
                if (w_mask_full) begin
                    pend_d      = 1'b1;
                    pend_snap_d = live_q;
                end
            end
            ACC_DONE: begin
                acc_state_d = ACC_IDLE;
                // Pending frame goes first; a frame completing now becomes the new pending one
                if (pend_q || w_mask_full) begin
                    acc_state_d = ACC_RUN;
                    shadow_d    = pend_q ? pend_snap_q : live_q;
                    idx_d       = LAST_IDX;
                    acc_d       = '0;
                    err_d       = 1'b0;
                    pend_d      = pend_q & w_mask_full;
                    if (pend_q && w_mask_full) pend_snap_d = live_q;
                end
            end
            default: acc_state_d = ACC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_state_q   <= IDLE;
            cnt_q         <= '0;
            prev_q        <= '0;
            an_cap_q      <= '0;
            pos_q         <= '0;
            code_q        <= '0;
            live_q        <= '0;
            mask_q        <= '0;
            acc_state_q   <= ACC_IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            err_q         <= 1'b0;
            shadow_q      <= '0;
            pend_q        <= 1'b0;
            pend_snap_q   <= '0;
            digits_q      <= '0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            cap_state_q   <= cap_state_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            an_cap_q      <= an_cap_d;
            pos_q         <= pos_d;
            code_q        <= code_d;
            live_q        <= live_d;
            mask_q        <= mask_d;
            acc_state_q   <= acc_state_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            err_q         <= err_d;
            shadow_q      <= shadow_d;
            pend_q        <= pend_d;
            pend_snap_q   <= pend_snap_d;
            digits_q      <= digits_d;
            value_q       <= value_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign digits      = digits_q;
    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule : seg7_scan_decoder
`default_nettype wire
